// File: rtl/reg_file_sb.sv
// Two-read / two-write register file with a per-register scoreboard busy bit.
// After reset, a sweep initialises one register per cycle, then the block enters RUN.
module reg_file_sb #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int INIT_MODE = 0,
  parameter int ZERO_REG  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  input  logic              wb_en0,
  input  logic              wb_en1,
  input  logic [ADDR_W-1:0] wb_dest0,
  input  logic [ADDR_W-1:0] wb_dest1,
  input  logic [DATA_W-1:0] wb_data0,
  input  logic [DATA_W-1:0] wb_data1,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_dest,
  output logic              busy1,
  output logic              busy2,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic run, we0, we1, rv;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return (INIT_MODE == 0) ? DATA_W'(a) : '0;
  endfunction

  // Writes and reservations are only honoured in RUN and never to a hardwired zero register.
  assign run   = (state_q == RUN);
  assign ready = run;
  assign we0   = run & wb_en0 & ~is_zero(wb_dest0);
  assign we1   = run & wb_en1 & ~is_zero(wb_dest1);
  assign rv    = run & rsv_en & ~is_zero(rsv_dest);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) state_d = RUN;
    end
  end

  // Reservation is applied last so a new producer wins over a completing one.
  always_comb begin
    busy_d = busy_q;
    if (we0) busy_d[wb_dest0] = 1'b0;
    if (we1) busy_d[wb_dest1] = 1'b0;
    if (rv)  busy_d[rsv_dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Port 1 is written after port 0 so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[cnt_q[ADDR_W-1:0]] <= init_val(cnt_q[ADDR_W-1:0]);
    end else begin
      if (we0) mem_q[wb_dest0] <= wb_data0;
      if (we1) mem_q[wb_dest1] <= wb_data1;
    end
  end

  always_comb begin
    reg1 = '0;
    if (run && !is_zero(src1)) begin
      if (we1 && wb_dest1 == src1)      reg1 = wb_data1;
      else if (we0 && wb_dest0 == src1) reg1 = wb_data0;
      else                              reg1 = mem_q[src1];
    end
  end

  always_comb begin
    reg2 = '0;
    if (run && !is_zero(src2)) begin
      if (we1 && wb_dest1 == src2)      reg2 = wb_data1;
      else if (we0 && wb_dest0 == src2) reg2 = wb_data0;
      else                              reg2 = mem_q[src2];
    end
  end

  // A producer completing this cycle already satisfies the consumer.
  always_comb begin
    busy1 = run && !is_zero(src1) && busy_q[src1]
            && !(we0 && wb_dest0 == src1) && !(we1 && wb_dest1 == src1);
    busy2 = run && !is_zero(src2) && busy_q[src2]
            && !(we0 && wb_dest0 == src2) && !(we1 && wb_dest1 == src2);
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a default instance and a ZERO_REG=1/INIT_MODE=1 instance
// share stimulus and are compared against an array-based reference model.
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic [3:0]  src1, src2, wb_dest0, wb_dest1, rsv_dest;
  logic        wb_en0, wb_en1, rsv_en;
  logic [31:0] wb_data0, wb_data1;
  logic [31:0] reg1, reg2, reg1_z, reg2_z;
  logic        busy1, busy2, ready, busy1_z, busy2_z, ready_z;

  reg_file_sb dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .reg1(reg1), .reg2(reg2),
    .wb_en0(wb_en0), .wb_en1(wb_en1), .wb_dest0(wb_dest0), .wb_dest1(wb_dest1),
    .wb_data0(wb_data0), .wb_data1(wb_data1), .rsv_en(rsv_en), .rsv_dest(rsv_dest),
    .busy1(busy1), .busy2(busy2), .ready(ready)
  );

  reg_file_sb #(.INIT_MODE(1), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .reg1(reg1_z), .reg2(reg2_z),
    .wb_en0(wb_en0), .wb_en1(wb_en1), .wb_dest0(wb_dest0), .wb_dest1(wb_dest1),
    .wb_data0(wb_data0), .wb_data1(wb_data1), .rsv_en(rsv_en), .rsv_dest(rsv_dest),
    .busy1(busy1_z), .busy2(busy2_z), .ready(ready_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: index 0 = default instance, index 1 = zero-register instance.
  logic [31:0] m_mem  [2][16];
  bit          m_busy [2][16];
  bit          m_run;
  int          m_cnt;

  function automatic bit dropped(input int z, input logic [3:0] a);
    return (z == 1) && (a == 4'd0);
  endfunction

  function automatic logic [31:0] exp_rd(input int z, input logic [3:0] a);
    if (!m_run || dropped(z, a)) return 32'd0;
    if (wb_en1 && wb_dest1 == a) return wb_data1;
    if (wb_en0 && wb_dest0 == a) return wb_data0;
    return m_mem[z][a];
  endfunction

  function automatic logic exp_busy(input int z, input logic [3:0] a);
    if (!m_run || dropped(z, a)) return 1'b0;
    if ((wb_en1 && wb_dest1 == a) || (wb_en0 && wb_dest0 == a)) return 1'b0;
    return m_busy[z][a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_run = 0;
      m_cnt = 0;
      for (int z = 0; z < 2; z++) for (int i = 0; i < 16; i++) m_busy[z][i] = 0;
    end else if (!m_run) begin
      m_mem[0][m_cnt] = m_cnt;
      m_mem[1][m_cnt] = 32'd0;
      if (m_cnt == 15) m_run = 1;
      m_cnt++;
    end else begin
      for (int z = 0; z < 2; z++) begin
        if (wb_en0 && !dropped(z, wb_dest0)) begin
          m_mem[z][wb_dest0] = wb_data0; m_busy[z][wb_dest0] = 0;
        end
        if (wb_en1 && !dropped(z, wb_dest1)) begin
          m_mem[z][wb_dest1] = wb_data1; m_busy[z][wb_dest1] = 0;
        end
        if (rsv_en && !dropped(z, rsv_dest)) m_busy[z][rsv_dest] = 1;
      end
    end
  endtask

  task automatic settle();
    #1;
    chk("ready",   ready,   m_run);
    chk("reg1",    reg1,    exp_rd(0, src1));
    chk("reg2",    reg2,    exp_rd(0, src2));
    chk("busy1",   busy1,   exp_busy(0, src1));
    chk("busy2",   busy2,   exp_busy(0, src2));
    chk("ready_z", ready_z, m_run);
    chk("reg1_z",  reg1_z,  exp_rd(1, src1));
    chk("reg2_z",  reg2_z,  exp_rd(1, src2));
    chk("busy1_z", busy1_z, exp_busy(1, src1));
    chk("busy2_z", busy2_z, exp_busy(1, src2));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    wb_en0 = 0; wb_en1 = 0; rsv_en = 0;
  endtask

  initial begin
    m_run = 0; m_cnt = 0;
    rst = 1; idle();
    src1 = 0; src2 = 0; wb_dest0 = 0; wb_dest1 = 0; rsv_dest = 0;
    wb_data0 = 0; wb_data1 = 0;
    @(negedge clk);
    tick();
    rst = 0;

    // Sweep: ready must stay low for 16 edges, then rise.
    for (int i = 0; i < 16; i++) begin
      settle();
      tick();
    end
    chk("rdy_after_sweep", ready, 1'b1);

    src1 = 5; src2 = 15;
    settle();
    chk("init_r5", reg1, 32'd5);
    chk("init_r15", reg2, 32'd15);
    chk("init_z_r5", reg1_z, 32'd0);

    src1 = 3; wb_en0 = 1; wb_dest0 = 3; wb_data0 = 32'hDEADBEEF;
    settle(); chk("byp0", reg1, 32'hDEADBEEF);
    tick(); idle();
    settle(); chk("wr0_hold", reg1, 32'hDEADBEEF);

    src1 = 7; wb_en0 = 1; wb_dest0 = 7; wb_data0 = 32'h11;
    wb_en1 = 1; wb_dest1 = 7; wb_data1 = 32'h22;
    settle(); chk("byp_p1_wins", reg1, 32'h22);
    tick(); idle();
    settle(); chk("wr_p1_wins", reg1, 32'h22);

    src1 = 9; rsv_en = 1; rsv_dest = 9;
    settle(); tick(); idle();
    settle(); chk("rsv_sets", busy1, 1'b1);
    wb_en1 = 1; wb_dest1 = 9; wb_data1 = 32'h99;
    settle(); chk("wb_clears_now", busy1, 1'b0);
    tick(); idle();
    rsv_en = 1; rsv_dest = 9; wb_en0 = 1; wb_dest0 = 9; wb_data0 = 32'h77;
    settle(); tick(); idle();
    settle(); chk("rsv_beats_wb", busy1, 1'b1);

    src1 = 0; wb_en0 = 1; wb_dest0 = 0; wb_data0 = 32'hFF; rsv_en = 1; rsv_dest = 0;
    settle(); chk("z_byp", reg1_z, 32'd0); chk("z_busy_now", busy1_z, 1'b0);
    tick(); idle();
    settle(); chk("z_rd", reg1_z, 32'd0); chk("z_busy", busy1_z, 1'b0);
    chk("nz_r0", reg1, 32'hFF); chk("nz_busy0", busy1, 1'b1);

    rsv_en = 1; rsv_dest = 4; wb_en0 = 1; wb_dest0 = 2; wb_data0 = 32'hAB;
    settle(); tick(); idle();
    src1 = 2; src2 = 4;
    settle(); chk("pre_rst_r2", reg1, 32'hAB); chk("pre_rst_b4", busy2, 1'b1);
    rst = 1; tick(); rst = 0;
    settle(); chk("rst_ready", ready, 1'b0); chk("rst_busy", busy2, 1'b0);
    for (int i = 0; i < 16; i++) begin
      settle();
      tick();
    end
    settle();
    chk("resweep_r2", reg1, 32'd2);
    chk("resweep_b4", busy2, 1'b0);

    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 149) == 0);
      wb_en0   = $urandom_range(0, 1);
      wb_en1   = $urandom_range(0, 1);
      rsv_en   = ($urandom_range(0, 2) == 0);
      wb_dest0 = 4'($urandom_range(0, 15));
      wb_dest1 = ($urandom_range(0, 3) == 0) ? wb_dest0 : 4'($urandom_range(0, 15));
      rsv_dest = ($urandom_range(0, 3) == 0) ? wb_dest1 : 4'($urandom_range(0, 15));
      wb_data0 = $urandom;
      wb_data1 = $urandom;
      src1     = ($urandom_range(0, 2) == 0) ? wb_dest0 : 4'($urandom_range(0, 15));
      src2     = ($urandom_range(0, 2) == 0) ? rsv_dest : 4'($urandom_range(0, 15));
      settle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
